// File: rtl/axi_pkg.sv
// Shared AXI constants and FSM state types for the memory responder.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

endpackage

// File: rtl/mem_1r1w.sv
// Simple dual-port array: synchronous write, registered read, read-before-write on collisions.
module mem_1r1w #(
    parameter int DEPTH = 4096,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rdata_r;

    // Array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read register holds its value until the next load.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= {WIDTH{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 burst memory responder with independent write and read FSMs.
// Optional burst range checking is enabled by defining AXI_MEM_SLAVE_RANGE_CHECK_EN.
module axi_mem_slave
    import axi_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    MEM_WORDS  = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awid,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bid,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arid,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic                  s_axi_rid,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int SHIFT = $clog2(DATA_WIDTH / 8);

    wr_state_e wr_state_r, wr_state_s;
    rd_state_e rd_state_r, rd_state_s;
    logic [IDX_W-1:0] wr_idx_r, rd_idx_r, aw_idx_s, ar_idx_s, raddr_s;
    logic [8:0]       wr_cnt_r, rd_cnt_r;
    logic             wr_err_r, rd_err_r, aw_err_s, ar_err_s;
    logic             bid_r, rid_r;
    logic             aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s, we_s, re_s;
    logic [DATA_WIDTH-1:0] mem_rdata_s;
    logic             unused_s;

    assign unused_s = ^{s_axi_awsize, s_axi_awburst ^ BURST_INCR, s_axi_awprot, s_axi_wlast,
                        s_axi_arsize, s_axi_arburst ^ BURST_INCR, s_axi_arprot};

    assign aw_idx_s = IDX_W'((s_axi_awaddr - BASE_ADDR) >> SHIFT);
    assign ar_idx_s = IDX_W'((s_axi_araddr - BASE_ADDR) >> SHIFT);

`ifdef AXI_MEM_SLAVE_RANGE_CHECK_EN
    function automatic logic burst_ok(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len);
        logic [ADDR_WIDTH:0] last_word;
        last_word = (ADDR_WIDTH+1)'((addr - BASE_ADDR) >> SHIFT) + (ADDR_WIDTH+1)'(len);
        return (addr >= BASE_ADDR) && (last_word < (ADDR_WIDTH+1)'(MEM_WORDS));
    endfunction

    assign aw_err_s = !burst_ok(s_axi_awaddr, s_axi_awlen);
    assign ar_err_s = !burst_ok(s_axi_araddr, s_axi_arlen);
`else
    assign aw_err_s = 1'b0;
    assign ar_err_s = 1'b0;
`endif

    assign aw_hs_s = s_axi_awvalid && (wr_state_r == W_IDLE);
    assign w_hs_s  = s_axi_wvalid  && (wr_state_r == W_DATA);
    assign b_hs_s  = s_axi_bready  && (wr_state_r == W_RESP);
    assign ar_hs_s = s_axi_arvalid && (rd_state_r == R_IDLE);
    assign r_hs_s  = s_axi_rready  && (rd_state_r == R_DATA);

    // A beat landing in the reset cycle must not reach the array.
    assign we_s    = w_hs_s && !wr_err_r && !rst;
    assign re_s    = ar_hs_s || (r_hs_s && (rd_cnt_r != 9'd1));
    assign raddr_s = ar_hs_s ? ar_idx_s : rd_idx_r;

    // FSM state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_r <= W_IDLE;
            rd_state_r <= R_IDLE;
        end else begin
            wr_state_r <= wr_state_s;
            rd_state_r <= rd_state_s;
        end
    end

    // Write FSM next-state logic.
    always_comb begin
        wr_state_s = wr_state_r;
        case (wr_state_r)
            W_IDLE: if (aw_hs_s) wr_state_s = W_DATA; else wr_state_s = W_IDLE;
            W_DATA: if (w_hs_s && (wr_cnt_r == 9'd1)) wr_state_s = W_RESP; else wr_state_s = W_DATA;
            W_RESP: if (b_hs_s) wr_state_s = W_IDLE; else wr_state_s = W_RESP;
            default: wr_state_s = W_IDLE;
        endcase
    end

    // Read FSM next-state logic.
    always_comb begin
        rd_state_s = rd_state_r;
        case (rd_state_r)
            R_IDLE: if (ar_hs_s) rd_state_s = R_DATA; else rd_state_s = R_IDLE;
            R_DATA: if (r_hs_s && (rd_cnt_r == 9'd1)) rd_state_s = R_IDLE; else rd_state_s = R_DATA;
            default: rd_state_s = R_IDLE;
        endcase
    end

    // Handshake and response outputs decoded from registered state only.
    always_comb begin
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (wr_state_r)
            W_IDLE:  s_axi_awready = 1'b1;
            W_DATA:  s_axi_wready  = 1'b1;
            W_RESP:  s_axi_bvalid  = 1'b1;
            default: s_axi_awready = 1'b0;
        endcase
        s_axi_arready = (rd_state_r == R_IDLE);
        s_axi_rvalid  = (rd_state_r == R_DATA);
        s_axi_rlast   = (rd_state_r == R_DATA) && (rd_cnt_r == 9'd1);
        s_axi_bid     = bid_r;
        s_axi_rid     = rid_r;
        if (wr_err_r) s_axi_bresp = RESP_SLVERR; else s_axi_bresp = RESP_OKAY;
        if (rd_err_r) begin
            s_axi_rresp = RESP_SLVERR;
            s_axi_rdata = {DATA_WIDTH{1'b0}};
        end else begin
            s_axi_rresp = RESP_OKAY;
            s_axi_rdata = mem_rdata_s;
        end
    end

    // Write burst bookkeeping: index, remaining beats, id and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx_r <= {IDX_W{1'b0}};
            wr_cnt_r <= 9'd0;
            wr_err_r <= 1'b0;
            bid_r    <= 1'b0;
        end else if (aw_hs_s) begin
            wr_idx_r <= aw_idx_s;
            wr_cnt_r <= {1'b0, s_axi_awlen} + 9'd1;
            wr_err_r <= aw_err_s;
            bid_r    <= s_axi_awid;
        end else if (w_hs_s) begin
            wr_idx_r <= wr_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            wr_cnt_r <= wr_cnt_r - 9'd1;
        end
    end

    // Read burst bookkeeping; rd_idx_r always points at the next word to load.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_idx_r <= {IDX_W{1'b0}};
            rd_cnt_r <= 9'd0;
            rd_err_r <= 1'b0;
            rid_r    <= 1'b0;
        end else if (ar_hs_s) begin
            rd_idx_r <= ar_idx_s + {{(IDX_W-1){1'b0}}, 1'b1};
            rd_cnt_r <= {1'b0, s_axi_arlen} + 9'd1;
            rd_err_r <= ar_err_s;
            rid_r    <= s_axi_arid;
        end else if (r_hs_s) begin
            rd_idx_r <= rd_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            rd_cnt_r <= rd_cnt_r - 9'd1;
        end
    end

    mem_1r1w #(
        .DEPTH (MEM_WORDS),
        .WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (we_s),
        .waddr (wr_idx_r),
        .wdata (s_axi_wdata),
        .re    (re_s),
        .raddr (raddr_s),
        .rdata (mem_rdata_s)
    );

endmodule
